// File: rtl/gca_pkg.sv
// Shared definitions for the Gray-conversion arbiter: FSM state encoding and
// the requester-ID width helper.
package gca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } gca_state_e;

  // ID width for n requesters; never narrower than one bit
  function automatic int gca_idw(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/gca_rr_pick.sv
// Combinational requester pick: first set req_valid bit at or after rr_ptr,
// searched cyclically. Produces a one-hot grant, its index and an any-flag.
module gca_rr_pick
  import gca_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // cyclic first-set search starting at rr_ptr
  always_comb begin
    grant = {NREQ{1'b0}};
    idx   = {IDW{1'b0}};
    any   = 1'b0;
    cand  = {IDW{1'b0}};
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(rr_ptr) + off) % NREQ);
      if (!any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Arbitrates NREQ requesters onto one bit-serial binary-to-Gray engine.
// Define GCA_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr_ptr).
module gray_conv_arbiter
  import gca_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = gca_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int NW = $clog2(WIDTH);

  gca_state_e       state_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] gry_r;
  logic [IDW-1:0]   id_r;
  logic [NW-1:0]    n_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [NREQ-1:0]  pick_grant_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             pick_any_s;
  logic [IDW-1:0]   pick_ptr_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH-1:0] gray_full_s;
  logic [NW-1:0]    k_s;
  logic             grant_ok_s;

`ifdef GCA_FIXED_PRIO_EN
  assign pick_ptr_s = {IDW{1'b0}};
`else
  logic [IDW-1:0] rr_ptr_r;

  // round-robin pointer moves just past each granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {IDW{1'b0}};
    end else if (grant_ok_s) begin
      if (pick_idx_s == IDW'(NREQ - 1)) begin
        rr_ptr_r <= {IDW{1'b0}};
      end else begin
        rr_ptr_r <= pick_idx_s + IDW'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign pick_ptr_s = rr_ptr_r;
`endif

  gca_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req_valid(req_valid),
    .rr_ptr   (pick_ptr_s),
    .grant    (pick_grant_s),
    .idx      (pick_idx_s),
    .any      (pick_any_s)
  );

  // operand mux for the winning requester
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx_s == IDW'(i)) begin
        sel_data_s = req_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is asserted
  assign grant_ok_s  = pick_any_s && (state_r == ST_IDLE) && rst_n;
  assign req_ready   = pick_grant_s & {NREQ{grant_ok_s}};

  // Gray bit k is opnd_ext[k+1]^opnd_ext[k]; the engine writes it MSB first
  assign gray_full_s = opnd_r ^ {1'b0, opnd_r[WIDTH-1:1]};
  assign k_s         = NW'(WIDTH - 1) - n_r;

  // main FSM with operand/result registers and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      opnd_r      <= {WIDTH{1'b0}};
      gry_r       <= {WIDTH{1'b0}};
      id_r        <= {IDW{1'b0}};
      n_r         <= {NW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_ok_s) begin
            opnd_r  <= sel_data_s;
            id_r    <= pick_idx_s;
            gry_r   <= {WIDTH{1'b0}};
            n_r     <= {NW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_CONV;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONV: begin
          gry_r[k_s] <= gray_full_s[k_s];
          if (n_r == NW'(WIDTH - 1)) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            n_r <= n_r + NW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = gry_r;
  assign out_id    = id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: vector table plus hand-written
// contention, backpressure and mid-conversion reset sequences.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [15:0] data;
    logic [1:0]  exp_id;
    logic [3:0]  exp_gray;
  } vec_t;

  vec_t vecs[9];

  gray_conv_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one isolated transaction with out_ready high; starts and ends in IDLE
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    req_valid = v.rv;
    req_data  = v.data;
    out_ready = 1'b1;
    #1;
    check($sformatf("%s_grant", tag), 32'(req_ready), 32'(4'b0001 << v.exp_id));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s_latency", tag), 32'(lat), 32'(5));
    check($sformatf("%s_data", tag), 32'(out_data), 32'(v.exp_gray));
    check($sformatf("%s_id", tag), 32'(out_id), 32'(v.exp_id));
    check($sformatf("%s_busy", tag), 32'(busy), 32'(1'b1));
    @(posedge clk);
    #1;
    check($sformatf("%s_idle_valid", tag), 32'(out_valid), 32'(1'b0));
    check($sformatf("%s_idle_busy", tag), 32'(busy), 32'(1'b0));
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 30) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check($sformatf("%s_idle_timeout", tag), 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int ng;
    int cyc;
    int gid[5];
    int gcyc[5];
    int exp_ids[5];
    int lat;
    vec_t rv_vec;

    vecs[0] = '{rv: 4'b0001, data: {4'h0, 4'h0, 4'h0, 4'b1011}, exp_id: 2'd0, exp_gray: 4'b1110};
    vecs[1] = '{rv: 4'b0100, data: {4'h0, 4'b0000, 4'h0, 4'h0}, exp_id: 2'd2, exp_gray: 4'b0000};
    vecs[2] = '{rv: 4'b0100, data: {4'h0, 4'b0110, 4'h0, 4'h0}, exp_id: 2'd2, exp_gray: 4'b0101};
    vecs[3] = '{rv: 4'b0100, data: {4'h0, 4'b1111, 4'h0, 4'h0}, exp_id: 2'd2, exp_gray: 4'b1000};
    vecs[4] = '{rv: 4'b0100, data: {4'h0, 4'b1000, 4'h0, 4'h0}, exp_id: 2'd2, exp_gray: 4'b1100};
`ifdef GCA_FIXED_PRIO_EN
    vecs[5] = '{rv: 4'b1000, data: {4'b0011, 4'h0, 4'h0, 4'h0}, exp_id: 2'd3, exp_gray: 4'b0010};
    vecs[6] = '{rv: 4'b1001, data: {4'b1111, 4'h0, 4'h0, 4'b0101}, exp_id: 2'd0, exp_gray: 4'b0111};
    vecs[7] = '{rv: 4'b1001, data: {4'b1100, 4'h0, 4'h0, 4'b0001}, exp_id: 2'd0, exp_gray: 4'b0001};
`else
    vecs[5] = '{rv: 4'b1000, data: {4'b0011, 4'h0, 4'h0, 4'h0}, exp_id: 2'd3, exp_gray: 4'b0010};
    vecs[6] = '{rv: 4'b1001, data: {4'b1111, 4'h0, 4'h0, 4'b0101}, exp_id: 2'd0, exp_gray: 4'b0111};
    vecs[7] = '{rv: 4'b1001, data: {4'b1100, 4'h0, 4'h0, 4'b0001}, exp_id: 2'd3, exp_gray: 4'b1010};
`endif
    vecs[8] = '{rv: 4'b0010, data: {4'h0, 4'h0, 4'b0110, 4'h0}, exp_id: 2'd1, exp_gray: 4'b0101};

    // reset state, with requests asserted to confirm req_ready stays low
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 16'hA5C3;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(4'b0000));
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_out_data", 32'(out_data), 32'(4'b0000));
    check("rst_out_id", 32'(out_id), 32'(2'd0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // contention: four requesters held, out_ready high
`ifdef GCA_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    @(negedge clk);
    req_valid = 4'b1111;
    req_data  = 16'h1234;
    out_ready = 1'b1;
    ng  = 0;
    cyc = 0;
    while (ng < 5 && cyc < 60) begin
      #1;
      if (|req_ready) begin
        gid[ng] = 0;
        for (int j = 0; j < 4; j++) begin
          if (req_ready[j]) gid[ng] = j;
        end
        gcyc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 4'b0000;
    check("cont_grant_count", 32'(ng), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < ng) begin
        check($sformatf("cont_order%0d", i), 32'(gid[i]), 32'(exp_ids[i]));
        if (i > 0) check($sformatf("cont_spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'(6));
      end
    end
    wait_idle("cont");

    // backpressure: result held for 10 cycles while requests stay pending
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = {4'h0, 4'h0, 4'b0110, 4'h0};
    out_ready = 1'b0;
    #1;
`ifdef GCA_FIXED_PRIO_EN
    check("bp_grant", 32'(req_ready), 32'(4'b0010));
`else
    check("bp_grant", 32'(req_ready), 32'(4'b0010));
`endif
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(5));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'(1'b1));
      check($sformatf("bp_data%0d", i), 32'(out_data), 32'(4'b0101));
      check($sformatf("bp_id%0d", i), 32'(out_id), 32'(2'd1));
      check($sformatf("bp_noready%0d", i), 32'(req_ready), 32'(4'b0000));
    end
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("bp_release_busy", 32'(busy), 32'(1'b0));
    check("bp_release_valid", 32'(out_valid), 32'(1'b0));

    // reset in the middle of a conversion, at n=2
    @(negedge clk);
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b1011};
    out_ready = 1'b1;
    #1;
    check("mr_grant", 32'(req_ready), 32'(4'b0001));
    repeat (3) @(posedge clk);
    #1;
    check("mr_busy_before", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mr_req_ready", 32'(req_ready), 32'(4'b0000));
    check("mr_out_valid", 32'(out_valid), 32'(1'b0));
    check("mr_out_data", 32'(out_data), 32'(4'b0000));
    check("mr_out_id", 32'(out_id), 32'(2'd0));
    check("mr_busy", 32'(busy), 32'(1'b0));
    @(negedge clk);
    check("mr_held_ready", 32'(req_ready), 32'(4'b0000));
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mr_quiet%0d", i), 32'({busy, out_valid}), 32'(2'b00));
    end

    // pointer back at 0 after reset: 0 beats 3
    rv_vec = '{rv: 4'b1001, data: {4'b0111, 4'h0, 4'h0, 4'b0100}, exp_id: 2'd0, exp_gray: 4'b0110};
    run_vec(rv_vec, "post_rst");
    run_vec(vecs[8], "vec8");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
